reset_sequencer: RTL and testbench

Staged reset controller for the board-level reset tree. It holds every downstream reset domain asserted for a programmable hold time, then releases the domains one at a time in a fixed order with a programmable gap between releases. It arbitrates soft-reset requests from several requesters and records which source caused the most recent reset. It sits between the board reset input and the per-domain reset shift chains.

---
 rtl/reset_seq_pkg.sv | 18 +
 rtl/rst_seq_timer.sv | 46 ++++
 rtl/reset_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
// Optional watchdog support in the top is enabled with RSTSEQ_WDOG_EN.
package reset_seq_pkg;

  // Sequencer phases: all domains held, staged release, all domains released.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_e;

  // Bit position of the power-on flag inside the cause vector.
  // Soft-request sources occupy the bits below it.
  function automatic int cause_por_bit(input int num_req);
    return num_req;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count compare.
// Clear has priority over load, which has priority over increment.
module rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: clear, load, increment or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: holds all domains in reset for HOLD_CYCLES, then
// releases them one by one (bit 0 first) every STAGE_DELAY cycles. Soft
// requests restart the sequence and are recorded in the cause vector.
// Define RSTSEQ_WDOG_EN to add a watchdog that forces a reset from RUN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int HOLD_CYCLES  = 8,
  parameter int STAGE_DELAY  = 4,
  parameter int NUM_REQ      = 2,
  parameter int WDOG_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    soft_req,
`ifdef RSTSEQ_WDOG_EN
  input  logic                  wdog_kick,
  output logic                  wdog_cause,
`endif
  output logic [NUM_STAGES-1:0] rst_stage,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic [NUM_REQ:0]      cause
);

  localparam int MAX_CT = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int CNT_W  = $clog2(MAX_CT) + 1;
  localparam int IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int POR_B  = cause_por_bit(NUM_REQ);

  localparam logic [NUM_REQ:0] CAUSE_POR = (NUM_REQ+1)'(1) << POR_B;

  seq_state_e            state_d, state_q;
  logic [IDX_W-1:0]      idx_d, idx_q;
  logic [NUM_STAGES-1:0] rst_stage_d, rst_stage_q;
  logic                  seq_busy_d, seq_busy_q;
  logic                  seq_done_d, seq_done_q;
  logic [NUM_REQ:0]      cause_d, cause_q;

  logic                  soft_any_s;
  logic                  cnt_clr_s;
  logic                  cnt_inc_s;
  logic [CNT_W-1:0]      cnt_term_s;
  logic [CNT_W-1:0]      cnt_s;
  logic                  cnt_tc_s;
  logic                  wdog_expire_s;

  assign soft_any_s = |soft_req;

  // Phase counter: shared by the hold period and each inter-stage gap.
  rst_seq_timer #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr_s),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .inc      (cnt_inc_s),
    .term     (cnt_term_s),
    .cnt      (cnt_s),
    .tc       (cnt_tc_s)
  );

`ifdef RSTSEQ_WDOG_EN
  localparam int WD_W = $clog2(WDOG_TIMEOUT) + 1;
  // Expire on the edge that would take the count to WDOG_TIMEOUT-1.
  localparam int WD_T = (WDOG_TIMEOUT >= 2) ? (WDOG_TIMEOUT - 2) : 0;

  logic            wd_clr_s;
  logic            wd_inc_s;
  logic [WD_W-1:0] wd_cnt_s;
  logic            wd_tc_s;
  logic            wdog_cause_d, wdog_cause_q;

  // Watchdog counter runs only in RUN and is cleared by a kick.
  always_comb begin
    wdog_expire_s = (state_q == RUN) && !wdog_kick && wd_tc_s;
    if ((state_q != RUN) || wdog_kick || wdog_expire_s) begin
      wd_clr_s = 1'b1;
      wd_inc_s = 1'b0;
    end else begin
      wd_clr_s = 1'b0;
      wd_inc_s = 1'b1;
    end
  end

  rst_seq_timer #(.W(WD_W)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wd_clr_s),
    .load     (1'b0),
    .load_val ({WD_W{1'b0}}),
    .inc      (wd_inc_s),
    .term     (WD_W'(WD_T)),
    .cnt      (wd_cnt_s),
    .tc       (wd_tc_s)
  );

  // Sticky watchdog flag: set on expiry, cleared by any soft request.
  always_comb begin
    wdog_cause_d = wdog_cause_q;
    if (soft_any_s) begin
      wdog_cause_d = 1'b0;
    end else if (wdog_expire_s) begin
      wdog_cause_d = 1'b1;
    end else begin
      wdog_cause_d = wdog_cause_q;
    end
  end

  // Watchdog flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cause_q <= 1'b0;
    end else begin
      wdog_cause_q <= wdog_cause_d;
    end
  end

  assign wdog_cause = wdog_cause_q;
`else
  assign wdog_expire_s = 1'b0;
`endif

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rst_stage_d = rst_stage_q;
    cause_d     = cause_q;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    cnt_term_s  = CNT_W'(STAGE_DELAY - 1);

    case (state_q)
      HOLD: begin
        cnt_term_s = CNT_W'(HOLD_CYCLES - 1);
        if (soft_any_s) begin
          // Restart the hold period and accumulate new sources.
          cnt_clr_s   = 1'b1;
          idx_d       = {IDX_W{1'b0}};
          rst_stage_d = {NUM_STAGES{1'b1}};
          cause_d     = cause_q | {1'b0, soft_req};
        end else if (cnt_tc_s) begin
          state_d   = RELEASE;
          cnt_clr_s = 1'b1;
          idx_d     = {IDX_W{1'b0}};
        end else begin
          cnt_inc_s = 1'b1;
        end
      end

      RELEASE: begin
        if (soft_any_s) begin
          // Reassert any released domains and start over.
          state_d     = HOLD;
          cnt_clr_s   = 1'b1;
          idx_d       = {IDX_W{1'b0}};
          rst_stage_d = {NUM_STAGES{1'b1}};
          cause_d     = cause_q | {1'b0, soft_req};
        end else if (cnt_tc_s) begin
          rst_stage_d[idx_q] = 1'b0;
          cnt_clr_s          = 1'b1;
          if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
            state_d = RUN;
            idx_d   = {IDX_W{1'b0}};
          end else begin
            idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_inc_s = 1'b1;
        end
      end

      RUN: begin
        cnt_clr_s = 1'b1;
        if (soft_any_s) begin
          state_d     = HOLD;
          idx_d       = {IDX_W{1'b0}};
          rst_stage_d = {NUM_STAGES{1'b1}};
          cause_d     = {1'b0, soft_req};
        end else if (wdog_expire_s) begin
          state_d     = HOLD;
          idx_d       = {IDX_W{1'b0}};
          rst_stage_d = {NUM_STAGES{1'b1}};
          cause_d     = {(NUM_REQ+1){1'b0}};
        end else begin
          rst_stage_d = {NUM_STAGES{1'b0}};
        end
      end

      default: begin
        // Unreachable encoding: recover into a full reset hold.
        state_d     = HOLD;
        cnt_clr_s   = 1'b1;
        idx_d       = {IDX_W{1'b0}};
        rst_stage_d = {NUM_STAGES{1'b1}};
        cause_d     = CAUSE_POR;
      end
    endcase

    seq_busy_d = |rst_stage_d;
    seq_done_d = (state_d == RUN);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      idx_q       <= {IDX_W{1'b0}};
      rst_stage_q <= {NUM_STAGES{1'b1}};
      seq_busy_q  <= 1'b1;
      seq_done_q  <= 1'b0;
      cause_q     <= CAUSE_POR;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rst_stage_q <= rst_stage_d;
      seq_busy_q  <= seq_busy_d;
      seq_done_q  <= seq_done_d;
      cause_q     <= cause_d;
    end
  end

  assign rst_stage = rst_stage_q;
  assign seq_busy  = seq_busy_q;
  assign seq_done  = seq_done_q;
  assign cause     = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
module tb_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] soft_req;
  logic [2:0] rst_stage;
  logic       seq_busy;
  logic       seq_done;
  logic [2:0] cause;
`ifdef RSTSEQ_WDOG_EN
  logic       wdog_kick;
  logic       wdog_cause;
`endif

  int checks;
  int failures;

  reset_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .soft_req  (soft_req),
`ifdef RSTSEQ_WDOG_EN
    .wdog_kick (wdog_kick),
    .wdog_cause(wdog_cause),
`endif
    .rst_stage (rst_stage),
    .seq_busy  (seq_busy),
    .seq_done  (seq_done),
    .cause     (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic busy,
                         input logic done, input logic [2:0] cs);
    chk({tag, ".stage"}, 32'(rst_stage), 32'(st));
    chk({tag, ".busy"},  32'(seq_busy),  32'(busy));
    chk({tag, ".done"},  32'(seq_done),  32'(done));
    chk({tag, ".cause"}, 32'(cause),     32'(cs));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    soft_req = 2'b00;
`ifdef RSTSEQ_WDOG_EN
    wdog_kick = 1'b1;
`endif

    // Power-on reset for two edges.
    tick(2);
    chk_all("por", 3'b111, 1'b1, 1'b0, 3'b100);
    rst_n = 1'b1;

    // Edge 1 is the first edge with rst_n high.
    tick(11);
    chk_all("por.e11", 3'b111, 1'b1, 1'b0, 3'b100);
    tick(1);
    chk_all("por.e12", 3'b110, 1'b1, 1'b0, 3'b100);
    tick(3);
    chk("por.e15.stage", 32'(rst_stage), 32'h6);
    tick(1);
    chk_all("por.e16", 3'b100, 1'b1, 1'b0, 3'b100);
    tick(3);
    chk_all("por.e19", 3'b100, 1'b1, 1'b0, 3'b100);
    tick(1);
    chk_all("por.e20", 3'b000, 1'b0, 1'b1, 3'b100);
    tick(5);
    chk_all("run.stable", 3'b000, 1'b0, 1'b1, 3'b100);

    // Single-cycle soft request from requester 0 while in RUN.
    soft_req = 2'b01;
    tick(1);
    soft_req = 2'b00;
    chk_all("soft0.entry", 3'b111, 1'b1, 1'b0, 3'b001);
    tick(11);
    chk("soft0.s11.stage", 32'(rst_stage), 32'h7);
    tick(1);
    chk("soft0.s12.stage", 32'(rst_stage), 32'h6);
    tick(8);
    chk_all("soft0.s20", 3'b000, 1'b0, 1'b1, 3'b001);

    // Both requesters on the same edge: one sequence, both bits recorded.
    soft_req = 2'b11;
    tick(1);
    soft_req = 2'b00;
    chk_all("soft11.entry", 3'b111, 1'b1, 1'b0, 3'b011);
    tick(19);
    chk_all("soft11.s19", 3'b100, 1'b1, 1'b0, 3'b011);
    tick(1);
    chk_all("soft11.s20", 3'b000, 1'b0, 1'b1, 3'b011);

    // Restart during RELEASE: requester 1 pulses after stage 0 released.
    soft_req = 2'b01;
    tick(1);
    soft_req = 2'b00;
    chk("rst.entry.cause", 32'(cause), 32'h1);
    tick(13);
    chk_all("rst.s13", 3'b110, 1'b1, 1'b0, 3'b001);
    soft_req = 2'b10;
    tick(1);
    soft_req = 2'b00;
    chk_all("rst.s14", 3'b111, 1'b1, 1'b0, 3'b011);
    tick(12);
    chk("rst.r12.stage", 32'(rst_stage), 32'h6);
    tick(7);
    chk_all("rst.r19", 3'b100, 1'b1, 1'b0, 3'b011);
    tick(1);
    chk_all("rst.r20", 3'b000, 1'b0, 1'b1, 3'b011);

    // rst_n low during RELEASE with a request held: power-on cause wins.
    soft_req = 2'b01;
    tick(1);
    soft_req = 2'b00;
    tick(10);
    chk("por2.pre.stage", 32'(rst_stage), 32'h7);
    tick(2);
    chk("por2.release.stage", 32'(rst_stage), 32'h6);
    soft_req = 2'b01;
    rst_n    = 1'b0;
    tick(1);
    chk_all("por2.assert", 3'b111, 1'b1, 1'b0, 3'b100);
    rst_n = 1'b1;

    // Request still held after reset: accumulates and keeps HOLD.
    tick(1);
    chk_all("hold.acc", 3'b111, 1'b1, 1'b0, 3'b101);
    tick(25);
    chk_all("hold.long", 3'b111, 1'b1, 1'b0, 3'b101);
    soft_req = 2'b00;
    tick(11);
    chk("hold.f11.stage", 32'(rst_stage), 32'h7);
    tick(1);
    chk("hold.f12.stage", 32'(rst_stage), 32'h6);
    tick(8);
    chk_all("hold.f20", 3'b000, 1'b0, 1'b1, 3'b101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
